// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between the multi-cycle controller and the
// unified instruction/data memory. The controller is the master: it raises a
// read or write request, selects the address source, and waits for ready.
interface multicycle_ctrl_if;
    logic MemRead_o;
    logic MemWrite_o;
    logic IorD_o;
    logic mem_ready_i;

    modport master (
        output MemRead_o,
        output MemWrite_o,
        output IorD_o,
        input  mem_ready_i
    );

    modport slave (
        input  MemRead_o,
        input  MemWrite_o,
        input  IorD_o,
        output mem_ready_i
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Steps the shared datapath (one ALU, unified
// memory, IR, PC, register file) through one instruction at a time, and
// bounds every memory wait so a stuck memory cannot hang the core.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  FETCH  | read instruction at PC, PC+4 via ALU; load IR/PC on ready
//  DECODE | latch opcode, precompute branch target into ALUOut
//  EXEC   | R-type or immediate ALU operation / address calculation
//  MEM    | data read (lw) or write (sw) at ALUOut, wait for ready
//  WB     | register file write from ALUOut or MDR
//  BRANCH | compare rs/rt, conditional PC load from ALUOut
//  JUMP   | jump target to PC; jal also writes the link register
//  7      | unused encoding, recovers to FETCH with all controls off
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [5:0]               instr_op_i,
    multicycle_ctrl_if.master        memBus,
    output logic                     PCWrite_o,
    output logic                     IRWrite_o,
    output logic                     RegWrite_o,
    output logic [1:0]               RegDst_o,
    output logic [1:0]               MemToReg_o,
    output logic                     ALUSrcA_o,
    output logic [1:0]               ALUSrcB_o,
    output logic [2:0]               ALU_op_o,
    output logic                     ZeroExt_o,
    output logic                     Branch_o,
    output logic [1:0]               BranchType_o,
    output logic [1:0]               PCSrc_o,
    output logic [2:0]               state_o,
    output logic                     illegal_o,
    output logic                     mem_err_o
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] BRANCH = 3'd5;
    localparam logic [2:0] JUMP   = 3'd6;

    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_BLTZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLE   = 6'd6;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LI    = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int             CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       nextState;
    logic [5:0]       opQ;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] nextWaitCnt;

    logic       memWait;
    logic       pcWrite;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       srcA;
    logic [1:0] srcB;
    logic [2:0] aluOp;
    logic       zeroExt;
    logic       branch;
    logic [1:0] branchType;
    logic [1:0] pcSrc;
    logic       illegal;
    logic       memErr;

    logic       memReady;
    logic       isLw;
    logic       isSw;

    assign memReady = memBus.mem_ready_i;
    assign isLw     = (opQ == OP_LW);
    assign isSw     = (opQ == OP_SW);

    // State, latched opcode and memory wait counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= FETCH;
            opQ     <= '0;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
            if (state == DECODE) begin
                opQ <= instr_op_i;
            end
        end
    end

    // Next-state and per-state datapath controls; a timeout abort suppresses
    // every PC/IR/register write of that cycle by taking the not-ready path.
    always_comb begin
        nextState  = FETCH;
        memWait    = 1'b0;
        pcWrite    = 1'b0;
        irWrite    = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        iorD       = 1'b0;
        regWrite   = 1'b0;
        regDst     = 2'b00;
        memToReg   = 2'b00;
        srcA       = 1'b0;
        srcB       = 2'b00;
        aluOp      = 3'b000;
        zeroExt    = 1'b0;
        branch     = 1'b0;
        branchType = 2'b00;
        pcSrc      = 2'b00;
        illegal    = 1'b0;
        memErr     = 1'b0;

        case (state)
            FETCH: begin
                memWait = 1'b1;
                memRead = 1'b1;
                srcB    = 2'b01;
                aluOp   = 3'b010;
                if (memReady) begin
                    pcWrite   = 1'b1;
                    irWrite   = 1'b1;
                    nextState = DECODE;
                end else if (waitCnt == CNT_LAST) begin
                    memErr    = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextState = FETCH;
                end
            end

            DECODE: begin
                srcB  = 2'b11;
                aluOp = 3'b010;
                case (instr_op_i)
                    OP_R, OP_ADDI, OP_SLTIU, OP_ORI,
                    OP_LI, OP_LW, OP_SW:              nextState = EXEC;
                    OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ:  nextState = BRANCH;
                    OP_J, OP_JAL:                     nextState = JUMP;
                    default: begin
                        illegal   = 1'b1;
                        nextState = FETCH;
                    end
                endcase
            end

            EXEC: begin
                srcA = 1'b1;
                if (opQ == OP_R) begin
                    srcB  = 2'b00;
                    aluOp = 3'b000;
                end else begin
                    srcB = 2'b10;
                    case (opQ)
                        OP_SLTIU: aluOp = 3'b011;
                        OP_ORI: begin
                            aluOp   = 3'b101;
                            zeroExt = 1'b1;
                        end
                        default:  aluOp = 3'b010;
                    endcase
                end
                nextState = (isLw || isSw) ? MEM : WB;
            end

            MEM: begin
                memWait  = 1'b1;
                iorD     = 1'b1;
                memRead  = isLw;
                memWrite = isSw;
                if (memReady) begin
                    nextState = isLw ? WB : FETCH;
                end else if (waitCnt == CNT_LAST) begin
                    memErr    = 1'b1;
                    nextState = FETCH;
                end else begin
                    nextState = MEM;
                end
            end

            WB: begin
                regWrite = 1'b1;
                if (opQ == OP_R) begin
                    regDst = 2'b01;
                end else if (isLw) begin
                    memToReg = 2'b01;
                end
                nextState = FETCH;
            end

            BRANCH: begin
                srcA   = 1'b1;
                srcB   = 2'b00;
                aluOp  = 3'b001;
                branch = 1'b1;
                pcSrc  = 2'b01;
                case (opQ)
                    OP_BLE:  branchType = 2'b01;
                    OP_BLTZ: branchType = 2'b10;
                    OP_BNE:  branchType = 2'b11;
                    default: branchType = 2'b00;
                endcase
                nextState = FETCH;
            end

            JUMP: begin
                pcWrite = 1'b1;
                pcSrc   = 2'b10;
                // PC already holds the return address (PC+4) from FETCH.
                if (opQ == OP_JAL) begin
                    regWrite = 1'b1;
                    regDst   = 2'b10;
                    memToReg = 2'b10;
                end
                nextState = FETCH;
            end

            default: nextState = FETCH;
        endcase
    end

    // Wait counter restarts on every state entry (including a timeout re-entry
    // of FETCH) and counts only cycles spent waiting for memory.
    always_comb begin
        nextWaitCnt = waitCnt;
        if ((nextState != state) || memErr) begin
            nextWaitCnt = '0;
        end else if (memWait && !memReady) begin
            nextWaitCnt = waitCnt + CNT_W'(1);
        end
    end

    // All controls are forced low while reset is held, so an interrupted
    // memory write or register write is never completed.
    always_comb begin
        PCWrite_o         = rst_i & pcWrite;
        IRWrite_o         = rst_i & irWrite;
        memBus.MemRead_o  = rst_i & memRead;
        memBus.MemWrite_o = rst_i & memWrite;
        memBus.IorD_o     = rst_i & iorD;
        RegWrite_o        = rst_i & regWrite;
        RegDst_o          = rst_i ? regDst     : 2'b00;
        MemToReg_o        = rst_i ? memToReg   : 2'b00;
        ALUSrcA_o         = rst_i & srcA;
        ALUSrcB_o         = rst_i ? srcB       : 2'b00;
        ALU_op_o          = rst_i ? aluOp      : 3'b000;
        ZeroExt_o         = rst_i & zeroExt;
        Branch_o          = rst_i & branch;
        BranchType_o      = rst_i ? branchType : 2'b00;
        PCSrc_o           = rst_i ? pcSrc      : 2'b00;
        state_o           = rst_i ? state      : 3'b000;
        illegal_o         = rst_i & illegal;
        mem_err_o         = rst_i & memErr;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with MEM_TIMEOUT=4. Inputs change on the
// falling edge and outputs are checked 1 ns later; each step lists the ready
// input, opcode, expected state and expected control word.
module tb_multicycle_ctrl;

    // Control word field order:
    // PCWrite IRWrite MemRead MemWrite IorD RegWrite RegDst[2] MemToReg[2]
    // SrcA SrcB[2] ALU_op[3] ZeroExt Branch BranchType[2] PCSrc[2] illegal mem_err
    localparam logic [23:0] V_ZERO       = 24'b0_0_0_0_0_0_00_00_0_00_000_0_0_00_00_0_0;
    localparam logic [23:0] V_FETCH_RDY  = 24'b1_1_1_0_0_0_00_00_0_01_010_0_0_00_00_0_0;
    localparam logic [23:0] V_FETCH_WAIT = 24'b0_0_1_0_0_0_00_00_0_01_010_0_0_00_00_0_0;
    localparam logic [23:0] V_FETCH_ERR  = 24'b0_0_1_0_0_0_00_00_0_01_010_0_0_00_00_0_1;
    localparam logic [23:0] V_DECODE     = 24'b0_0_0_0_0_0_00_00_0_11_010_0_0_00_00_0_0;
    localparam logic [23:0] V_DEC_ILL    = 24'b0_0_0_0_0_0_00_00_0_11_010_0_0_00_00_1_0;
    localparam logic [23:0] V_EXEC_R     = 24'b0_0_0_0_0_0_00_00_1_00_000_0_0_00_00_0_0;
    localparam logic [23:0] V_EXEC_ADD   = 24'b0_0_0_0_0_0_00_00_1_10_010_0_0_00_00_0_0;
    localparam logic [23:0] V_EXEC_ORI   = 24'b0_0_0_0_0_0_00_00_1_10_101_1_0_00_00_0_0;
    localparam logic [23:0] V_MEM_LW     = 24'b0_0_1_0_1_0_00_00_0_00_000_0_0_00_00_0_0;
    localparam logic [23:0] V_MEM_SW     = 24'b0_0_0_1_1_0_00_00_0_00_000_0_0_00_00_0_0;
    localparam logic [23:0] V_MEM_SW_ERR = 24'b0_0_0_1_1_0_00_00_0_00_000_0_0_00_00_0_1;
    localparam logic [23:0] V_WB_R       = 24'b0_0_0_0_0_1_01_00_0_00_000_0_0_00_00_0_0;
    localparam logic [23:0] V_WB_I       = 24'b0_0_0_0_0_1_00_00_0_00_000_0_0_00_00_0_0;
    localparam logic [23:0] V_WB_LW      = 24'b0_0_0_0_0_1_00_01_0_00_000_0_0_00_00_0_0;
    localparam logic [23:0] V_BR_BEQ     = 24'b0_0_0_0_0_0_00_00_1_00_001_0_1_00_01_0_0;
    localparam logic [23:0] V_BR_BLTZ    = 24'b0_0_0_0_0_0_00_00_1_00_001_0_1_10_01_0_0;
    localparam logic [23:0] V_JAL        = 24'b1_0_0_0_0_1_10_10_0_00_000_0_0_00_10_0_0;

    logic       clk = 1'b0;
    logic       rstN;
    logic [5:0] instrOp;
    logic       pcWrite, irWrite, regWrite, srcA, zeroExt, branch, illegal, memErr;
    logic [1:0] regDst, memToReg, srcB, branchType, pcSrc;
    logic [2:0] aluOp, state;
    logic [23:0] obs;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_ctrl_if memBus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rstN),
        .instr_op_i   (instrOp),
        .memBus       (memBus),
        .PCWrite_o    (pcWrite),
        .IRWrite_o    (irWrite),
        .RegWrite_o   (regWrite),
        .RegDst_o     (regDst),
        .MemToReg_o   (memToReg),
        .ALUSrcA_o    (srcA),
        .ALUSrcB_o    (srcB),
        .ALU_op_o     (aluOp),
        .ZeroExt_o    (zeroExt),
        .Branch_o     (branch),
        .BranchType_o (branchType),
        .PCSrc_o      (pcSrc),
        .state_o      (state),
        .illegal_o    (illegal),
        .mem_err_o    (memErr)
    );

    always #5 clk = ~clk;

    assign obs = {pcWrite, irWrite, memBus.MemRead_o, memBus.MemWrite_o, memBus.IorD_o,
                  regWrite, regDst, memToReg, srcA, srcB, aluOp, zeroExt, branch,
                  branchType, pcSrc, illegal, memErr};

    task automatic test_reset();
        rstN = 1'b0;
        instrOp = 6'd0;
        memBus.mem_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (state !== 3'd0 || obs !== V_ZERO) begin
                miscompares++;
                $display("FAIL reset_hold step %0d: got state=%0d ctrl=%b, want state=0 ctrl=%b",
                         i, state, obs, V_ZERO);
            end
        end
        @(negedge clk);
        rstN = 1'b1;
        memBus.mem_ready_i = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || obs !== V_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL reset_release: got state=%0d ctrl=%b, want state=0 ctrl=%b",
                     state, obs, V_FETCH_WAIT);
        end
    endtask

    task automatic test_r_add();
        logic        rdy [5];
        logic [2:0]  st  [5];
        logic [23:0] ev  [5];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        st  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        ev  = '{V_FETCH_RDY, V_DECODE, V_EXEC_R, V_WB_R, V_FETCH_WAIT};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memBus.mem_ready_i = rdy[i];
            instrOp = 6'd0;
            #1;
            vectors++;
            if (state !== st[i] || obs !== ev[i]) begin
                miscompares++;
                $display("FAIL r_add step %0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state, obs, st[i], ev[i]);
            end
        end
    endtask

    task automatic test_lw_delayed();
        logic        rdy [9];
        logic [2:0]  st  [9];
        logic [23:0] ev  [9];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        ev  = '{V_FETCH_RDY, V_DECODE, V_EXEC_ADD, V_MEM_LW, V_MEM_LW, V_MEM_LW,
                V_MEM_LW, V_WB_LW, V_FETCH_WAIT};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            memBus.mem_ready_i = rdy[i];
            instrOp = 6'd35;
            #1;
            vectors++;
            if (state !== st[i] || obs !== ev[i]) begin
                miscompares++;
                $display("FAIL lw_delayed step %0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state, obs, st[i], ev[i]);
            end
        end
    endtask

    task automatic test_sw_timeout();
        logic        rdy [8];
        logic [2:0]  st  [8];
        logic [23:0] ev  [8];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
        ev  = '{V_FETCH_RDY, V_DECODE, V_EXEC_ADD, V_MEM_SW, V_MEM_SW, V_MEM_SW,
                V_MEM_SW_ERR, V_FETCH_WAIT};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            memBus.mem_ready_i = rdy[i];
            instrOp = 6'd43;
            #1;
            vectors++;
            if (state !== st[i] || obs !== ev[i]) begin
                miscompares++;
                $display("FAIL sw_timeout step %0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state, obs, st[i], ev[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  op  [7];
        logic        rdy [7];
        logic [2:0]  st  [7];
        logic [23:0] ev  [7];
        op  = '{6'd4, 6'd4, 6'd4, 6'd1, 6'd1, 6'd1, 6'd1};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        st  = '{3'd0, 3'd1, 3'd5, 3'd0, 3'd1, 3'd5, 3'd0};
        ev  = '{V_FETCH_RDY, V_DECODE, V_BR_BEQ, V_FETCH_RDY, V_DECODE, V_BR_BLTZ, V_FETCH_WAIT};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            memBus.mem_ready_i = rdy[i];
            instrOp = op[i];
            #1;
            vectors++;
            if (state !== st[i] || obs !== ev[i]) begin
                miscompares++;
                $display("FAIL branch step %0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state, obs, st[i], ev[i]);
            end
        end
    endtask

    task automatic test_jump_illegal();
        logic [5:0]  op  [5];
        logic [2:0]  st  [5];
        logic [23:0] ev  [5];
        op = '{6'd3, 6'd3, 6'd3, 6'd63, 6'd63};
        st = '{3'd0, 3'd1, 3'd6, 3'd0, 3'd1};
        ev = '{V_FETCH_RDY, V_DECODE, V_JAL, V_FETCH_RDY, V_DEC_ILL};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memBus.mem_ready_i = 1'b1;
            instrOp = op[i];
            #1;
            vectors++;
            if (state !== st[i] || obs !== ev[i]) begin
                miscompares++;
                $display("FAIL jump_illegal step %0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state, obs, st[i], ev[i]);
            end
        end
    endtask

    // Starts on the FETCH entered from the illegal opcode, times out the
    // fetch, then runs an ori back to back through WB.
    task automatic test_fetch_timeout();
        logic        rdy [10];
        logic [2:0]  st  [10];
        logic [23:0] ev  [10];
        rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        st  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        ev  = '{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_ERR, V_FETCH_WAIT,
                V_FETCH_RDY, V_DECODE, V_EXEC_ORI, V_WB_I, V_FETCH_WAIT};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            memBus.mem_ready_i = rdy[i];
            instrOp = 6'd13;
            #1;
            vectors++;
            if (state !== st[i] || obs !== ev[i]) begin
                miscompares++;
                $display("FAIL fetch_timeout step %0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state, obs, st[i], ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic        rdy [5];
        logic [2:0]  st  [5];
        logic [23:0] ev  [5];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        ev  = '{V_FETCH_RDY, V_DECODE, V_EXEC_ADD, V_MEM_LW, V_MEM_LW};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memBus.mem_ready_i = rdy[i];
            instrOp = 6'd35;
            #1;
            vectors++;
            if (state !== st[i] || obs !== ev[i]) begin
                miscompares++;
                $display("FAIL reset_mid step %0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                         i, state, obs, st[i], ev[i]);
            end
        end
        #2;
        rstN = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || obs !== V_ZERO) begin
            miscompares++;
            $display("FAIL reset_mid_async: got state=%0d ctrl=%b, want state=0 ctrl=%b",
                     state, obs, V_ZERO);
        end
        @(negedge clk);
        memBus.mem_ready_i = 1'b1;
        #1;
        vectors++;
        if (state !== 3'd0 || obs !== V_ZERO) begin
            miscompares++;
            $display("FAIL reset_mid_hold: got state=%0d ctrl=%b, want state=0 ctrl=%b",
                     state, obs, V_ZERO);
        end
        @(negedge clk);
        rstN = 1'b1;
        memBus.mem_ready_i = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || obs !== V_FETCH_WAIT) begin
            miscompares++;
            $display("FAIL reset_mid_release: got state=%0d ctrl=%b, want state=0 ctrl=%b",
                     state, obs, V_FETCH_WAIT);
        end
    endtask

    initial begin
        test_reset();
        test_r_add();
        test_lw_delayed();
        test_sw_timeout();
        test_branch();
        test_jump_illegal();
        test_fetch_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
